lfsr_parity_checker: RTL and testbench

Receive-side checker for the 8-bit parity-protected PRBS words produced by the team's 7-bit LFSR generator, whose output is bit 7 = NOT(XOR of bits 6:0) and bits 6:0 = LFSR state. It sits directly downstream of the generator (or at the far end of a link carrying its output). It checks parity on every word, self-synchronises to the LFSR sequence, and reports lock status plus saturating parity and sequence error counts.

---
 rtl/lfsr_pkg.sv | 23 ++
 rtl/sat_counter.sv | 31 +++
 rtl/lfsr_parity_checker.sv | 160 ++++++++++++++++
 tb/tb_lfsr_parity_checker.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 7-bit PRBS generator and its receive-side checker:
// state encoding, LFSR width, next-state and parity functions.
package lfsr_pkg;

  localparam int LFSR_W = 7;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lfsr_state_e;

  // Maximal-length 7-bit Fibonacci step, period 127; all-zero is a lock-up state.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

  // Parity bit carried in bit 7 of each word: odd parity over the whole byte.
  function automatic logic lfsr_parity(input logic [LFSR_W-1:0] s);
    return ~^s;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] count_r;

  // Count register: reset, then clear, then saturating increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/lfsr_parity_checker.sv
// Receive-side checker for parity-protected 7-bit PRBS words: per-word parity check,
// self-synchronising sequence lock with flywheel, and saturating error counters.
module lfsr_parity_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_in,
  input  logic             valid_in,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             par_err,
  output logic             seq_err,
  output logic [CNT_W-1:0] par_err_cnt,
  output logic [CNT_W-1:0] seq_err_cnt
);

  localparam logic [3:0] LOCK_TGT   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_TGT = 4'(UNLOCK_CNT);

  lfsr_state_e       state_r;
  lfsr_state_e       state_s;
  logic [LFSR_W-1:0] expected_r;
  logic [LFSR_W-1:0] expected_s;
  logic [LFSR_W-1:0] field_s;
  logic [3:0]        match_cnt_r;
  logic [3:0]        match_cnt_s;
  logic [3:0]        match_inc_s;
  logic [3:0]        miss_cnt_r;
  logic [3:0]        miss_cnt_s;
  logic [3:0]        miss_inc_s;
  logic              par_ok_s;
  logic              seed_ok_s;
  logic              par_hit_s;
  logic              seq_hit_s;
  logic              locked_r;
  logic              par_err_r;
  logic              seq_err_r;

  assign field_s     = data_in[LFSR_W-1:0];
  assign par_ok_s    = (data_in[7] == lfsr_parity(field_s));
  assign seed_ok_s   = par_ok_s && (field_s != {LFSR_W{1'b0}});
  assign par_hit_s   = valid_in && !par_ok_s;
  assign match_inc_s = match_cnt_r + 4'd1;
  assign miss_inc_s  = miss_cnt_r + 4'd1;

  // Next-state logic for the lock FSM and its tracking registers.
  always_comb begin
    state_s     = state_r;
    expected_s  = expected_r;
    match_cnt_s = match_cnt_r;
    miss_cnt_s  = miss_cnt_r;
    seq_hit_s   = 1'b0;
    if (valid_in) begin
      case (state_r)
        HUNT: begin
          if (seed_ok_s) begin
            expected_s  = lfsr_next(field_s);
            match_cnt_s = 4'd1;
            if (LOCK_TGT == 4'd1) begin
              state_s    = LOCKED;
              miss_cnt_s = 4'd0;
            end else begin
              state_s = VERIFY;
            end
          end else begin
            state_s = HUNT;
          end
        end
        VERIFY: begin
          if (par_ok_s && (field_s == expected_r)) begin
            expected_s  = lfsr_next(field_s);
            match_cnt_s = match_inc_s;
            if (match_inc_s == LOCK_TGT) begin
              state_s    = LOCKED;
              miss_cnt_s = 4'd0;
            end else begin
              state_s = VERIFY;
            end
          end else if (seed_ok_s) begin
            expected_s  = lfsr_next(field_s);
            match_cnt_s = 4'd1;
            state_s     = VERIFY;
          end else begin
            match_cnt_s = 4'd0;
            state_s     = HUNT;
          end
        end
        LOCKED: begin
          // Flywheel: prediction advances from itself, never from the received word.
          expected_s = lfsr_next(expected_r);
          if (field_s != expected_r) begin
            seq_hit_s  = 1'b1;
            miss_cnt_s = miss_inc_s;
            if (miss_inc_s == UNLOCK_TGT) begin
              match_cnt_s = 4'd0;
              state_s     = HUNT;
            end else begin
              state_s = LOCKED;
            end
          end else begin
            miss_cnt_s = 4'd0;
            state_s    = LOCKED;
          end
        end
        default: begin
          state_s = HUNT;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State, prediction and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= HUNT;
      expected_r  <= {LFSR_W{1'b0}};
      match_cnt_r <= 4'd0;
      miss_cnt_r  <= 4'd0;
      locked_r    <= 1'b0;
      par_err_r   <= 1'b0;
      seq_err_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      expected_r  <= expected_s;
      match_cnt_r <= match_cnt_s;
      miss_cnt_r  <= miss_cnt_s;
      locked_r    <= (state_s == LOCKED);
      par_err_r   <= par_hit_s;
      seq_err_r   <= seq_hit_s;
    end
  end

  sat_counter #(.W(CNT_W)) u_par_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (par_hit_s),
    .clr   (clr_cnt),
    .count (par_err_cnt)
  );

  sat_counter #(.W(CNT_W)) u_seq_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (seq_hit_s),
    .clr   (clr_cnt),
    .count (seq_err_cnt)
  );

  assign locked  = locked_r;
  assign par_err = par_err_r;
  assign seq_err = seq_err_r;

endmodule

// File: tb/tb_lfsr_parity_checker.sv
// Scoreboard bench for lfsr_parity_checker: directed test-plan scenarios plus a
// randomized phase, each cycle checked against a behavioural reference model.
module tb_lfsr_parity_checker;

  localparam int LOCK_CNT   = 4;
  localparam int UNLOCK_CNT = 3;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       data_in = 8'h00;
  logic             valid_in = 1'b0;
  logic             clr_cnt = 1'b0;
  logic             locked;
  logic             par_err;
  logic             seq_err;
  logic [CNT_W-1:0] par_err_cnt;
  logic [CNT_W-1:0] seq_err_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit lk;
    bit pe;
    bit se;
    int pc;
    int sc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: lock flag, run of consecutive predicted words, miss run.
  bit m_locked = 1'b0;
  int m_run    = 0;
  int m_miss   = 0;
  int m_exp    = 0;
  int m_pc     = 0;
  int m_sc     = 0;
  int gen      = 1;

  always #5 clk = ~clk;

  lfsr_parity_checker #(
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_CNT (UNLOCK_CNT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .clr_cnt     (clr_cnt),
    .locked      (locked),
    .par_err     (par_err),
    .seq_err     (seq_err),
    .par_err_cnt (par_err_cnt),
    .seq_err_cnt (seq_err_cnt)
  );

  // Shift left within 7 bits, feed back the XOR of the two top bits.
  function automatic int nxt(input int s);
    int b6;
    int b5;
    b6 = (s / 64) % 2;
    b5 = (s / 32) % 2;
    return ((s * 2) % 128) + ((b6 + b5) % 2);
  endfunction

  // Word as the generator emits it: parity bit set when the field has an even number of ones.
  function automatic logic [7:0] word_of(input int f);
    logic [6:0] fld;
    logic       p;
    fld = 7'(f);
    p   = ($countones(fld) % 2 == 0) ? 1'b1 : 1'b0;
    return {p, fld};
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input logic [7:0] d, input bit c,
                            output exp_t e);
    int f;
    bit good;
    e.pe = 1'b0;
    e.se = 1'b0;
    if (r) begin
      m_locked = 1'b0;
      m_run    = 0;
      m_miss   = 0;
      m_exp    = 0;
      m_pc     = 0;
      m_sc     = 0;
    end else begin
      f    = int'(d[6:0]);
      good = (d[7] == (($countones(d[6:0]) % 2) == 0));
      if (v) begin
        e.pe = !good;
        if (m_locked) begin
          if (f != m_exp) begin
            e.se = 1'b1;
            m_miss++;
          end else begin
            m_miss = 0;
          end
          m_exp = nxt(m_exp);
          if (m_miss == UNLOCK_CNT) begin
            m_locked = 1'b0;
            m_run    = 0;
          end
        end else if (m_run > 0 && good && f == m_exp) begin
          m_run++;
          m_exp = nxt(f);
          if (m_run == LOCK_CNT) begin
            m_locked = 1'b1;
            m_miss   = 0;
          end
        end else if (good && f != 0) begin
          m_run = 1;
          m_exp = nxt(f);
          if (LOCK_CNT == 1) begin
            m_locked = 1'b1;
            m_miss   = 0;
          end
        end else begin
          m_run = 0;
        end
      end
      if (c) begin
        m_pc = 0;
        m_sc = 0;
      end else begin
        if (e.pe && m_pc < CNT_MAX) m_pc++;
        if (e.se && m_sc < CNT_MAX) m_sc++;
      end
    end
    e.lk = m_locked;
    e.pc = m_pc;
    e.sc = m_sc;
  endtask

  // Drive one clock of stimulus, queue its expected response, return 2 time units past the edge.
  task automatic cycle(input bit r, input bit v, input logic [7:0] d, input bit c);
    exp_t e;
    rst      = r;
    valid_in = v;
    data_in  = d;
    clr_cnt  = c;
    model_step(r, v, d, c, e);
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic send_seq(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 1'b1, word_of(gen), 1'b0);
      gen = nxt(gen);
    end
  endtask

  task automatic send_bad_field();
    cycle(1'b0, 1'b1, word_of(gen ^ 1), 1'b0);
    gen = nxt(gen);
  endtask

  // Monitor: after each edge, compare outputs against the oldest queued expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_locked", locked, e.lk);
        check("sb_par_err", par_err, e.pe);
        check("sb_seq_err", seq_err, e.se);
        check("sb_par_err_cnt", par_err_cnt, e.pc);
        check("sb_seq_err_cnt", seq_err_cnt, e.sc);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, got %0d checks, expected completion", checks);
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    bit         r;
    bit         v;
    bit         c;
    int         k;
    logic [7:0] w;

    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    check("reset_locked", locked, 0);
    check("reset_par_cnt", par_err_cnt, 0);
    check("reset_seq_cnt", seq_err_cnt, 0);

    // Clean lock on 0x01, 0x02, 0x04, 0x08.
    gen = 1;
    send_seq(3);
    check("lock_not_yet", locked, 0);
    send_seq(1);
    check("lock_after_4", locked, 1);
    send_seq(130);
    check("clean_par_cnt", par_err_cnt, 0);
    check("clean_seq_cnt", seq_err_cnt, 0);
    check("clean_locked", locked, 1);

    // Parity error while locked: 0x90 in place of 0x10.
    for (int i = 0; i < 130 && gen != 16; i++) send_seq(1);
    check("gen_at_0x10", int'(word_of(gen) ^ 8'h80), 8'h90);
    cycle(1'b0, 1'b1, word_of(gen) ^ 8'h80, 1'b0);
    gen = nxt(gen);
    check("perr_pulse", par_err, 1);
    check("perr_cnt", par_err_cnt, 1);
    check("perr_no_seq", seq_err, 0);
    check("perr_locked", locked, 1);
    send_seq(1);
    check("perr_pulse_end", par_err, 0);

    // Two isolated misses are absorbed by the flywheel, three in a row drop lock.
    send_bad_field();
    check("miss1_seq_err", seq_err, 1);
    send_seq(2);
    send_bad_field();
    send_seq(2);
    check("fly_seq_cnt", seq_err_cnt, 2);
    check("fly_locked", locked, 1);
    send_bad_field();
    send_bad_field();
    check("drop_after_2", locked, 1);
    send_bad_field();
    check("drop_after_3", locked, 0);
    check("drop_seq_cnt", seq_err_cnt, 5);

    // Hunt rejection of an all-zero field and a bad-parity word.
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h80, 1'b0);
    check("hunt_80_par", par_err, 0);
    cycle(1'b0, 1'b1, 8'h81, 1'b0);
    check("hunt_81_par", par_err, 1);
    check("hunt_81_cnt", par_err_cnt, 1);
    check("hunt_locked", locked, 0);
    gen = 2;
    send_seq(4);
    check("hunt_relock", locked, 1);

    // Saturation at 15, then clear wins over a coincident increment.
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 8'h81, 1'b0);
    check("sat_par_cnt", par_err_cnt, 15);
    cycle(1'b0, 1'b1, 8'h81, 1'b1);
    check("clr_par_cnt", par_err_cnt, 0);
    check("clr_par_pulse", par_err, 1);

    // Reset mid-lock with non-zero counters, then a fresh relock.
    gen = 35;
    send_seq(4);
    check("ml_locked", locked, 1);
    cycle(1'b0, 1'b1, word_of(gen) ^ 8'h80, 1'b0);
    gen = nxt(gen);
    send_bad_field();
    check("ml_par_cnt", par_err_cnt, 1);
    check("ml_seq_cnt", seq_err_cnt, 1);
    cycle(1'b1, 1'b1, word_of(gen), 1'b1);
    gen = nxt(gen);
    check("ml_rst_locked", locked, 0);
    check("ml_rst_pe", par_err, 0);
    check("ml_rst_se", seq_err, 0);
    check("ml_rst_pc", par_err_cnt, 0);
    check("ml_rst_sc", seq_err_cnt, 0);
    send_seq(3);
    check("ml_relock_3", locked, 0);
    send_seq(1);
    check("ml_relock_4", locked, 1);

    // Randomized traffic: gaps, corruption, clears and occasional resets.
    for (int i = 0; i < 900; i++) begin
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 29) == 0);
      k = $urandom_range(0, 19);
      w = word_of(gen);
      if (k == 0) begin
        w = w ^ 8'h80;
      end else if (k == 1) begin
        w = w ^ (8'h01 << $urandom_range(0, 6));
      end else if (k == 2) begin
        w = 8'($urandom);
      end
      cycle(r, v, w, c);
      if (v && !r) gen = nxt(gen);
    end

    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
